// File: rtl/uart_buf_pkg.sv
// Shared types and helpers for the UART batch buffer.
//   batch_state_e   : batch-mode FSM states (FILL collects, DRAIN releases)
//   buf_mode_e      : latched buffer mode (stream loopback or batch burst)
//   clamp_batch_len : maps a requested batch length onto 1..depth
package uart_buf_pkg;

    typedef enum logic {FILL, DRAIN} batch_state_e;
    typedef enum logic {MODE_STREAM, MODE_BATCH} buf_mode_e;

    // Zero or oversize requests mean "a whole FIFO's worth".
    function automatic int unsigned clamp_batch_len(input int unsigned len,
                                                    input int unsigned depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   push_i      : write wr_data_i (caller guarantees !full_c)
//   pop_i       : drop the head word (caller guarantees !empty_c)
//   rd_data_c   : head word, combinational from the read pointer
//   count_o     : registered occupancy
//   full_c      : count_o == DEPTH
//   empty_c     : count_o == 0
module sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);

endmodule

// File: rtl/uart_batch_buffer.sv
// AXI-stream buffer between uart_rx and uart_tx.
//   clk, rst        : clock, synchronous active-high reset
//   mode_i          : 0 stream loopback, 1 batch burst (latched when idle)
//   batch_len_i     : batch size, 0 or > DEPTH means DEPTH
//   flush_i         : batch mode, release a partial batch
//   s_axis_*        : word stream from uart_rx
//   m_axis_*        : word stream to uart_tx
//   overrun_i       : overrun pulse from uart_rx
//   count_o/full_o/empty_o : FIFO occupancy status
//   overrun_cnt_o   : saturating overrun event count
module uart_batch_buffer import uart_buf_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned OVR_W      = 8,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_i,
    input  logic [CNT_W-1:0]      batch_len_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  overrun_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [OVR_W-1:0]      overrun_cnt_o
);

    batch_state_e     state_q, state_d;
    buf_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;

    logic             push, pop, load;
    logic [CNT_W-1:0] count_after;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (s_axis_tdata),
        .pop_i     (pop),
        .rd_data_c (m_axis_tdata),
        .count_o   (count_o),
        .full_c    (full_o),
        .empty_c   (empty_o)
    );

    // Handshake gating; both sides are held low in the reset cycle so no
    // transfer can complete while contents are being discarded.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        if (!rst) begin
            if (mode_q == MODE_STREAM) begin
                s_axis_tready = !full_o;
                m_axis_tvalid = !empty_o;
            end else if (state_q == FILL) begin
                s_axis_tready = !full_o;
            end else begin
                m_axis_tvalid = !empty_o;
            end
        end
    end

    assign push        = s_axis_tvalid & s_axis_tready;
    assign pop         = m_axis_tvalid & m_axis_tready;
    assign load        = (count_o == '0) && (state_q == FILL);
    assign count_after = count_o + CNT_W'(push) - CNT_W'(pop);

    // Mode latch, batch FSM and overrun counter.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        ovr_cnt_d = ovr_cnt_q;

        if (load) begin
            mode_d = buf_mode_e'(mode_i);
            len_d  = CNT_W'(clamp_batch_len(32'(batch_len_i), DEPTH));
        end

        if (mode_q == MODE_BATCH) begin
            if (state_q == FILL) begin
                if (push && (count_after == len_q))           state_d = DRAIN;
                else if (flush_i && (count_after != '0))      state_d = DRAIN;
            end else begin
                if (pop && (count_o == CNT_W'(1)))            state_d = FILL;
            end
        end

        if (overrun_i && (ovr_cnt_q != {OVR_W{1'b1}})) ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            mode_q    <= MODE_STREAM;
            len_q     <= CNT_W'(DEPTH);
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;

endmodule

// File: tb/tb_uart_batch_buffer.sv
// Directed self-checking bench for uart_batch_buffer.
// Two instances share the stimulus: a_* is DEPTH=16, b_* is DEPTH=4.
module tb_uart_batch_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_i = 1'b0;
    logic [4:0] batch_len = '0;
    logic       flush_i = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       m_tready = 1'b0;
    logic       overrun_i = 1'b0;

    logic       a_tready, a_tvalid, a_full, a_empty;
    logic [7:0] a_tdata, a_ovr;
    logic [4:0] a_count;

    logic       b_tready, b_tvalid, b_full, b_empty;
    logic [7:0] b_tdata, b_ovr;
    logic [2:0] b_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_batch_buffer #(.DATA_WIDTH(8), .DEPTH(16), .OVR_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .mode_i(mode_i), .batch_len_i(batch_len),
        .flush_i(flush_i), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_tready), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(m_tready), .overrun_i(overrun_i), .count_o(a_count),
        .full_o(a_full), .empty_o(a_empty), .overrun_cnt_o(a_ovr)
    );

    uart_batch_buffer #(.DATA_WIDTH(8), .DEPTH(4), .OVR_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .mode_i(mode_i), .batch_len_i(batch_len[2:0]),
        .flush_i(flush_i), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_tready), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(m_tready), .overrun_i(overrun_i), .count_o(b_count),
        .full_o(b_full), .empty_o(b_empty), .overrun_cnt_o(b_ovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic mode, input logic [4:0] len);
        mode_i    = mode;
        batch_len = len;
        s_tvalid  = 1'b0;
        flush_i   = 1'b0;
        overrun_i = 1'b0;
        rst       = 1'b1;
        step();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full",  32'(a_full), 32'd0);
        chk("rst_mvalid", 32'(a_tvalid), 32'd0);
        chk("rst_sready", 32'(a_tready), 32'd0);
        chk("rst_ovr", 32'(a_ovr), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_sready", 32'(a_tready), 32'd1);
        step();
        step();
    endtask

    task automatic push_word(input logic [7:0] w);
        s_tdata  = w;
        s_tvalid = 1'b1;
        chk("push_ready", 32'(a_tready), 32'd1);
        step();
        s_tvalid = 1'b0;
    endtask

    logic acc;

    initial begin
        // Reset and stream loopback, one word at a time.
        do_reset(1'b0, 5'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_word(8'(8'h11 * (i + 1)));
            chk("s1_valid", 32'(a_tvalid), 32'd1);
            chk("s1_data", 32'(a_tdata), 32'(8'h11 * (i + 1)));
            chk("s1_count", 32'(a_count), 32'd1);
            step();
            chk("s1_empty", 32'(a_count), 32'd0);
        end

        // Stream mode on the 4-deep instance: fill, refuse the 5th, drain in order.
        do_reset(1'b0, 5'd0);
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tdata  = 8'(8'h40 + i);
            s_tvalid = 1'b1;
            step();
        end
        chk("s2_full", 32'(b_full), 32'd1);
        chk("s2_sready", 32'(b_tready), 32'd0);
        s_tdata = 8'h44;
        step();
        chk("s2_held", 32'(b_count), 32'd4);
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("s2_data", 32'(b_tdata), 32'(8'h40 + k));
            chk("s2_valid", 32'(b_tvalid), 32'd1);
            acc = b_tready & s_tvalid;
            step();
            if (acc) s_tvalid = 1'b0;
        end
        chk("s2_drained", 32'(b_empty), 32'd1);
        chk("s2_count0", 32'(b_count), 32'd0);

        // Batch of three words.
        do_reset(1'b1, 5'd3);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("b1_hold", 32'(a_tvalid), 32'd0);
            push_word(8'(8'hA0 + i));
        end
        chk("b1_release", 32'(a_tvalid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("b1_data", 32'(a_tdata), 32'(8'hA0 + k));
            chk("b1_sready", 32'(a_tready), 32'd0);
            step();
        end
        chk("b1_done_valid", 32'(a_tvalid), 32'd0);
        chk("b1_done_empty", 32'(a_empty), 32'd1);
        chk("b1_done_sready", 32'(a_tready), 32'd1);

        // Partial batch released by flush.
        batch_len = 5'd8;
        step();
        push_word(8'hB0);
        push_word(8'hB1);
        chk("fl_hold", 32'(a_tvalid), 32'd0);
        chk("fl_count", 32'(a_count), 32'd2);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_valid", 32'(a_tvalid), 32'd1);
        chk("fl_data0", 32'(a_tdata), 32'hB0);
        step();
        chk("fl_data1", 32'(a_tdata), 32'hB1);
        step();
        chk("fl_empty", 32'(a_empty), 32'd1);
        chk("fl_sready", 32'(a_tready), 32'd1);

        // Flush with an empty buffer stays in FILL.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fe_sready", 32'(a_tready), 32'd1);
        chk("fe_valid", 32'(a_tvalid), 32'd0);
        push_word(8'hF0);
        chk("fe_fill", 32'(a_tvalid), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fe_rel", 32'(a_tdata), 32'hF0);
        step();

        // Mode toggle mid-drain is deferred until empty.
        batch_len = 5'd3;
        step();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'(8'hC0 + i));
        mode_i = 1'b0;
        step();
        chk("mt_valid", 32'(a_tvalid), 32'd1);
        chk("mt_sready", 32'(a_tready), 32'd0);
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("mt_data", 32'(a_tdata), 32'(8'hC0 + k));
            step();
        end
        chk("mt_fill", 32'(a_tready), 32'd1);
        step();
        push_word(8'hD0);
        chk("mt_stream_valid", 32'(a_tvalid), 32'd1);
        chk("mt_stream_data", 32'(a_tdata), 32'hD0);
        step();

        // Reset mid-drain with two words left.
        mode_i = 1'b1;
        step();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'(8'hE0 + i));
        m_tready = 1'b1;
        step();
        chk("rd_count2", 32'(a_count), 32'd2);
        rst = 1'b1;
        #1;
        chk("rd_gate_valid", 32'(a_tvalid), 32'd0);
        step();
        rst = 1'b0;
        chk("rd_empty", 32'(a_empty), 32'd1);
        chk("rd_valid", 32'(a_tvalid), 32'd0);
        chk("rd_count", 32'(a_count), 32'd0);

        // Overrun counter counts and saturates.
        overrun_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        overrun_i = 1'b0;
        chk("ov_3", 32'(a_ovr), 32'd3);
        overrun_i = 1'b1;
        for (int i = 0; i < 297; i++) step();
        overrun_i = 1'b0;
        step();
        chk("ov_sat16", 32'(a_ovr), 32'd255);
        chk("ov_sat4", 32'(b_ovr), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_batch_buffer.md
Name: uart_batch_buffer

Overview:
Parametrised AXI-stream buffer between the UART receiver's master stream and the UART transmitter's slave stream. It replaces the direct rx-to-tx wiring and has two modes:
- Stream mode: FIFO-buffered loopback.
- Batch mode: collects a programmable number of words and releases them as one burst. This is the framing the sorting datapath will consume.

It also counts receiver overrun events.

Parameters:
- DATA_WIDTH, 8, word width of both streams.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy and batch length (derived, not overridden).
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mode_i  in  1  0 = stream, 1 = batch
- batch_len_i  in  CNT_W  batch size; 0 or > DEPTH treated as DEPTH
- flush_i  in  1  batch mode: release a partial batch
- s_axis_tdata  in  DATA_WIDTH  word from uart_rx
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  buffer accepts word
- m_axis_tdata  out  DATA_WIDTH  word to uart_tx
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  uart_tx accepts word
- overrun_i  in  1  single-cycle overrun pulse from uart_rx
- count_o  out  CNT_W  current occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- overrun_cnt_o  out  OVR_W  saturating overrun count

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- Values during and after reset:
  - Pointers, count_o and overrun_cnt_o are 0.
  - empty_o=1, full_o=0, m_axis_tvalid=0, s_axis_tready=0.
  - FSM is in FILL, mode_q=0, len_q=DEPTH.
  - s_axis_tready goes high the first cycle after rst deasserts.
- Reset mid-drain discards all contents. No partial handshake may complete in the reset cycle.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready. Both take effect on the rising edge.
- FIFO is first-word-fall-through:
  - m_axis_tdata = mem[rd_ptr] combinationally.
  - Pointers wrap modulo DEPTH.
  - count updates +1 on push only, -1 on pop only, unchanged on both.
- Mode latching:
  - mode_q and len_q load from mode_i and batch_len_i only on cycles where count_o==0 and the FSM is in FILL.
  - Mode changes while data is held are deferred until the buffer empties.
- Stream mode (mode_q=0):
  - s_axis_tready = !full_o; m_axis_tvalid = !empty_o.
  - A word pushed at edge N is presented on m_axis at cycle N+1 (latency 1).
  - When full, the push is refused even if a pop occurs in the same cycle.
  - When empty, no pop is possible, so there is no bypass.
  - The FSM stays in FILL.
- Batch mode (mode_q=1), two-state FSM:
  - FILL:
    - s_axis_tready = !full_o; m_axis_tvalid = 0.
    - Go to DRAIN on the edge where a push makes count == len_q.
    - Also go to DRAIN on any edge where flush_i=1 and count (after that edge's push) > 0.
    - flush_i with an empty buffer is ignored.
  - DRAIN:
    - s_axis_tready = 0; m_axis_tvalid = !empty_o.
    - Return to FILL on the edge of the last pop (count 1 -> 0).
    - s_axis_tready rises the following cycle.
  - Release latency: m_axis_tvalid rises the cycle after the completing push or flush.
  - flush_i during DRAIN has no effect.
- Overrun counter: increments on each cycle with overrun_i=1 and saturates at 2^OVR_W-1. It is cleared only by rst.
- AXI rules: m_axis_tvalid never drops without a pop, and m_axis_tdata is stable while tvalid=1 and tready=0.

Decomposition:
- Package uart_buf_pkg holds:
  - typedef enum logic {FILL, DRAIN} batch_state_e
  - typedef enum logic {MODE_STREAM, MODE_BATCH} buf_mode_e
  - the function clamping batch length to 1..DEPTH
- Natural sub-module: sync_fifo_fwft (DATA_WIDTH, DEPTH), providing push/pop/count/full/empty.
- uart_batch_buffer wraps it with the mode latch, the FSM, the ready/valid gating and the overrun counter.
- The system top instantiates uart_rx -> uart_batch_buffer -> uart_tx.

Test Plan:
- Reset, then idle with m_axis_tready=1:
  - During reset: count_o=0, empty_o=1, m_axis_tvalid=0, overrun_cnt_o=0, s_axis_tready=0.
  - s_axis_tready=1 one cycle after rst falls.
- Stream mode, push 0x11, 0x22, 0x33 with m_axis_tready=1:
  - Each word appears on m_axis one cycle after acceptance, in order.
  - count_o never exceeds 1.
- Stream mode, DEPTH=4, m_axis_tready=0, push 5 words:
  - After 4 pushes, full_o=1 and s_axis_tready=0; the 5th word is held at source.
  - Raise tready: 4 words drain in order, then the 5th is accepted.
- Batch mode, batch_len_i=3, push 0xA0, 0xA1, 0xA2:
  - m_axis_tvalid=0 until the edge after the 3rd push, then three words in order.
  - s_axis_tready=0 throughout the drain and 1 after the last pop.
- Batch mode, batch_len_i=8, push 2 words then pulse flush_i: both words are released.
- Corner cases:
  - flush_i with an empty buffer leaves the FSM in FILL.
  - Toggling mode_i mid-drain has no effect until count_o returns to 0.
  - Asserting rst mid-drain with 2 words left gives empty_o=1 and m_axis_tvalid=0 after the reset edge.
  - 300 overrun_i pulses give overrun_cnt_o=255.
